// File: rtl/cordic_vec_sched.sv
// Round-robin scheduler sharing one fixed-latency CORDIC vectoring engine.
// Define CORDIC_SCHED_CH0_PRIO_EN to give channel 0 strict priority.
module cordic_vec_sched #(
  parameter int NUM_CH = 4,
  parameter int DW     = 12,
  parameter int LAT    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [NUM_CH-1:0]       req_valid_i,
  input  logic [NUM_CH*DW-1:0]    req_x_i,
  input  logic [NUM_CH*DW-1:0]    req_y_i,
  output logic [NUM_CH-1:0]       req_ready_o,
  output logic                    cor_valid_o,
  output logic [DW-1:0]           cor_x_o,
  output logic [DW-1:0]           cor_y_o,
  input  logic                    cor_valid_i,
  input  logic [DW-1:0]           cor_z_i,
  output logic [NUM_CH-1:0]       rsp_valid_o,
  output logic [DW-1:0]           rsp_z_o,
  output logic [$clog2(NUM_CH)-1:0] rsp_ch_o,
  output logic                    busy_o,
  output logic                    tag_err_o
);

  localparam int CW = $clog2(NUM_CH);
  localparam int NW = $clog2(LAT + 2);
`ifdef CORDIC_SCHED_CH0_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic [CW-1:0] ptr;
  logic [CW-1:0] gnt_idx;
  logic [CW-1:0] idx;
  logic          found;
  logic          xfer;
  logic [CW-1:0] iss_ch;
  logic [DW-1:0] sel_x;
  logic [DW-1:0] sel_y;
  logic [LAT-1:0] tag_v;
  logic [CW-1:0]  tag_c [LAT];
  logic          tv;
  logic [CW-1:0] tc;
  logic [NW-1:0] cnt;

  // Channel 0 is skipped by the pointer search when it has priority.
  always_comb begin
    req_ready_o = '0;
    gnt_idx     = '0;
    found       = 1'b0;
    idx         = '0;
    if (enable_i) begin
      if (PRIO && req_valid_i[0]) begin
        req_ready_o[0] = 1'b1;
        found          = 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        idx = ptr + CW'(i);
        if (!found && !(PRIO && idx == '0) && req_valid_i[idx]) begin
          req_ready_o[idx] = 1'b1;
          gnt_idx          = idx;
          found            = 1'b1;
        end
      end
    end
  end

  assign xfer  = |(req_valid_i & req_ready_o);
  assign sel_x = req_x_i[int'(gnt_idx)*DW +: DW];
  assign sel_y = req_y_i[int'(gnt_idx)*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      cor_valid_o <= 1'b0;
      cor_x_o     <= '0;
      cor_y_o     <= '0;
      iss_ch      <= '0;
    end else begin
      cor_valid_o <= xfer;
      if (xfer) begin
        cor_x_o <= sel_x;
        cor_y_o <= sel_y;
        iss_ch  <= gnt_idx;
        if (!(PRIO && gnt_idx == '0)) ptr <= gnt_idx + 1'b1;
      end
    end
  end

  // Tags enter from the registered issue so the tail lines up with cor_valid_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= cor_valid_o;
      for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_c[0] <= iss_ch;
    for (int i = 1; i < LAT; i++) tag_c[i] <= tag_c[i-1];
  end

  assign tv = tag_v[LAT-1];
  assign tc = tag_c[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_o <= '0;
      rsp_z_o     <= '0;
      rsp_ch_o    <= '0;
      tag_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      tag_err_o   <= tv ^ cor_valid_i;
      if (tv && cor_valid_i) begin
        rsp_valid_o <= NUM_CH'(1) << tc;
        rsp_z_o     <= cor_z_i;
        rsp_ch_o    <= tc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (xfer && !tv) begin
      cnt <= cnt + 1'b1;
    end else if (!xfer && tv) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy_o = (cnt != '0);

endmodule

// File: tb/tb_cordic_vec_sched.sv
// Directed bench for cordic_vec_sched with a fixed-latency engine stub.
// Stub result: z = x + 7*y + 4, with optional drop of one selected issue.
module tb_cordic_vec_sched;

  localparam int NUM_CH = 4;
  localparam int DW     = 12;
  localparam int LAT    = 14;
`ifdef CORDIC_SCHED_CH0_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable_i = 1'b0;
  logic [NUM_CH-1:0]    req_valid_i = '0;
  logic [NUM_CH*DW-1:0] req_x_i = '0;
  logic [NUM_CH*DW-1:0] req_y_i = '0;
  logic [NUM_CH-1:0]    req_ready_o;
  logic                 cor_valid_o;
  logic [DW-1:0]        cor_x_o;
  logic [DW-1:0]        cor_y_o;
  logic                 cor_valid_i;
  logic [DW-1:0]        cor_z_i;
  logic [NUM_CH-1:0]    rsp_valid_o;
  logic [DW-1:0]        rsp_z_o;
  logic [1:0]           rsp_ch_o;
  logic                 busy_o;
  logic                 tag_err_o;

  cordic_vec_sched #(.NUM_CH(NUM_CH), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_x_i(req_x_i), .req_y_i(req_y_i),
    .req_ready_o(req_ready_o),
    .cor_valid_o(cor_valid_o), .cor_x_o(cor_x_o), .cor_y_o(cor_y_o),
    .cor_valid_i(cor_valid_i), .cor_z_i(cor_z_i),
    .rsp_valid_o(rsp_valid_o), .rsp_z_o(rsp_z_o), .rsp_ch_o(rsp_ch_o),
    .busy_o(busy_o), .tag_err_o(tag_err_o)
  );

  always #5 clk = ~clk;

  logic          sv [LAT];
  logic [DW-1:0] sz [LAT];
  int            stub_cnt = 0;
  logic          drop_en = 1'b0;
  int            drop_sel = 0;

  initial for (int i = 0; i < LAT; i++) begin
    sv[i] = 1'b0;
    sz[i] = '0;
  end

  always @(posedge clk) begin
    sv[0] <= cor_valid_o && !(drop_en && stub_cnt == drop_sel);
    sz[0] <= cor_x_o + DW'(7) * cor_y_o + DW'(4);
    for (int i = 1; i < LAT; i++) begin
      sv[i] <= sv[i-1];
      sz[i] <= sz[i-1];
    end
    if (cor_valid_o) stub_cnt <= stub_cnt + 1;
  end

  assign cor_valid_i = sv[LAT-1];
  assign cor_z_i     = sz[LAT-1];

  logic [17:0] rsp_q[$];
  int          err_cnt = 0;

  always @(negedge clk) begin
    if (rsp_valid_o != '0) rsp_q.push_back({rsp_valid_o, rsp_ch_o, rsp_z_o});
    if (tag_err_o) err_cnt <= err_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable_i    = 1'b0;
    req_valid_i = '0;
    rst         = 1'b1;
    #1;
    chk("rst_cor_valid", cor_valid_o, 0);
    chk("rst_cor_x", cor_x_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_z", rsp_z_o, 0);
    chk("rst_rsp_ch", rsp_ch_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tag_err", tag_err_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (busy_o && n < bound) begin
      step();
      n++;
    end
    chk("drain_busy", busy_o, 0);
  endtask

  task automatic set_xy(input int k, input int x, input int y);
    req_x_i[k*DW +: DW] = DW'(x);
    req_y_i[k*DW +: DW] = DW'(y);
  endtask

  typedef struct {
    logic       en;
    logic [3:0] v;
    logic [3:0] rr;
    logic [3:0] pr;
  } vec_t;

  vec_t        tbl [10];
  logic [3:0]  exp_g;
  logic [17:0] e;
  int          ng, qb, eb, n, ex;
  int          seq_rr [5];

  initial begin
    tbl[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{1'b0, 4'b1111, 4'b0000, 4'b0000};
    tbl[2] = '{1'b1, 4'b1010, 4'b0010, 4'b0010};
    tbl[3] = '{1'b1, 4'b1010, 4'b1000, 4'b1000};
    tbl[4] = '{1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[5] = '{1'b1, 4'b0101, 4'b0100, 4'b0001};
    tbl[6] = '{1'b1, 4'b0101, 4'b0001, 4'b0001};
    tbl[7] = '{1'b1, 4'b1110, 4'b0010, 4'b0010};
    tbl[8] = '{1'b1, 4'b0010, 4'b0010, 4'b0010};
    tbl[9] = '{1'b1, 4'b1001, 4'b1000, 4'b0001};
    seq_rr = '{0, 1, 2, 3, 0};

    // single request latency
    do_reset();
    set_xy(2, 100, 100);
    enable_i    = 1'b1;
    req_valid_i = 4'b0100;
    #1;
    chk("single_ready", req_ready_o, 4'b0100);
    step();
    req_valid_i = '0;
    chk("single_cor_valid", cor_valid_o, 1);
    chk("single_cor_x", cor_x_o, 100);
    chk("single_cor_y", cor_y_o, 100);
    n = 1;
    while (n < 40 && rsp_valid_o == '0) begin
      step();
      n++;
    end
    chk("single_rsp_cycle", n, 16);
    chk("single_rsp_valid", rsp_valid_o, 4'b0100);
    chk("single_rsp_z", rsp_z_o, 804);
    chk("single_rsp_ch", rsp_ch_o, 2);
    chk("single_busy_done", busy_o, 0);
    step();
    chk("single_rsp_clear", rsp_valid_o, 0);
    chk("single_z_hold", rsp_z_o, 804);

    // arbitration table
    do_reset();
    for (int k = 0; k < NUM_CH; k++) set_xy(k, 10 * (k + 1), k);
    qb = rsp_q.size();
    eb = err_cnt;
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      enable_i    = tbl[i].en;
      req_valid_i = tbl[i].v;
      exp_g       = PRIO ? tbl[i].pr : tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready_o, exp_g);
      ex = 0;
      for (int k = 0; k < NUM_CH; k++) if (exp_g[k]) ex = 10 * (k + 1);
      step();
      chk($sformatf("tbl%0d_cor_valid", i), cor_valid_o, (exp_g != '0));
      if (exp_g != '0) begin
        ng++;
        chk($sformatf("tbl%0d_cor_x", i), cor_x_o, ex);
      end
    end
    req_valid_i = '0;
    drain(60);
    step();
    chk("tbl_rsp_count", rsp_q.size() - qb, ng);
    chk("tbl_err_count", err_cnt - eb, 0);

    // all channels continuously valid
    do_reset();
    enable_i    = 1'b1;
    req_valid_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = PRIO ? 4'b0001 : 4'(1 << (c % 4));
      chk($sformatf("rr%0d_ready", c), req_ready_o, exp_g);
      step();
    end
    req_valid_i = '0;
    drain(60);

    // one result suppressed by the engine
    do_reset();
    for (int k = 0; k < NUM_CH; k++) set_xy(k, 20 * k, k);
    qb          = rsp_q.size();
    eb          = err_cnt;
    drop_sel    = stub_cnt + 1;
    drop_en     = 1'b1;
    enable_i    = 1'b1;
    req_valid_i = 4'b1110;
    repeat (3) step();
    req_valid_i = '0;
    drain(60);
    step();
    drop_en = 1'b0;
    chk("drop_err_count", err_cnt - eb, 1);
    chk("drop_rsp_count", rsp_q.size() - qb, 2);
    if (rsp_q.size() - qb == 2) begin
      e = rsp_q[qb];
      chk("drop_rsp0_valid", e[17:14], 4'b0010);
      chk("drop_rsp0_ch", e[13:12], 1);
      chk("drop_rsp0_z", e[11:0], 31);
      e = rsp_q[qb + 1];
      chk("drop_rsp1_valid", e[17:14], 4'b1000);
      chk("drop_rsp1_ch", e[13:12], 3);
      chk("drop_rsp1_z", e[11:0], 85);
    end

    // enable dropped with five results in flight
    do_reset();
    for (int k = 0; k < NUM_CH; k++) set_xy(k, 5 + k, 0);
    qb          = rsp_q.size();
    eb          = err_cnt;
    enable_i    = 1'b1;
    req_valid_i = 4'b1111;
    repeat (5) step();
    enable_i = 1'b0;
    #1;
    chk("en_off_ready", req_ready_o, 0);
    chk("en_off_busy", busy_o, 1);
    drain(60);
    chk("en_off_last_rsp", (rsp_valid_o != '0), 1);
    step();
    req_valid_i = '0;
    chk("en_off_rsp_count", rsp_q.size() - qb, 5);
    chk("en_off_err_count", err_cnt - eb, 0);
    if (rsp_q.size() - qb == 5) begin
      for (int i = 0; i < 5; i++) begin
        e  = rsp_q[qb + i];
        ex = PRIO ? 0 : seq_rr[i];
        chk($sformatf("en_off_rsp%0d_ch", i), e[13:12], ex);
        chk($sformatf("en_off_rsp%0d_z", i), e[11:0], 9 + ex);
      end
    end

    // reset with three results in flight
    do_reset();
    enable_i    = 1'b1;
    req_valid_i = 4'b0111;
    repeat (3) step();
    req_valid_i = '0;
    enable_i    = 1'b0;
    repeat (3) step();
    chk("mid_busy", busy_o, 1);
    do_reset();
    qb = rsp_q.size();
    eb = err_cnt;
    repeat (30) step();
    chk("mid_err_count", err_cnt - eb, 3);
    chk("mid_rsp_count", rsp_q.size() - qb, 0);
    chk("mid_busy_after", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
